// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// per-port completion pulses with read data/error and an ACCESS timeout.
module apb_master_arb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d, gnt_q, gnt_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              elig0, elig1, gnt_sel, timeout_hit, finish, xfer_err;
  logic [DATA_W-1:0] xfer_rdata;

  // A port is masked in its own done cycle so a held valid is seen as a new command.
  assign elig0       = req0_valid & ~done0_q;
  assign elig1       = req1_valid & ~done1_q;
  assign gnt_sel     = (elig0 & elig1) ? ~last_q : elig1;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));
  assign finish      = (state_q == ACCESS) && (pready || timeout_hit);
  assign xfer_err    = pready ? pslverr : 1'b1;
  assign xfer_rdata  = pready ? prdata : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (elig0 | elig1) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = err0_q;
    err1_d   = err1_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt_d    = gnt_sel;
          pwrite_d = gnt_sel ? req1_write : req0_write;
          paddr_d  = gnt_sel ? req1_addr  : req0_addr;
          pwdata_d = gnt_sel ? req1_wdata : req0_wdata;
        end
      end
      // Counter holds the index of the current ACCESS cycle (first one is 1).
      SETUP: cnt_d = CNT_W'(1);
      ACCESS: begin
        if (finish) begin
          cnt_d  = '0;
          last_d = gnt_q;
          if (gnt_q) begin
            done1_d = 1'b1;
            err1_d  = xfer_err;
            if (!pwrite_q) rdata1_d = xfer_rdata;
          end else begin
            done0_d = 1'b1;
            err0_d  = xfer_err;
            if (!pwrite_q) rdata0_d = xfer_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q     <= '0;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign busy       = psel_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: behavioural APB completer plus an in-order
// scoreboard of expected completions (port, err, rdata).
module tb_apb_master_arb;
  logic       pclk, presetn;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_done, req0_err, req1_done, req1_err;
  logic [7:0] req0_rdata, req1_rdata;
  logic       busy, psel, penable, pwrite, pready, pslverr;
  logic [7:0] paddr, pwdata, prdata;

  apb_master_arb #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Completer: pready after wait_n ACCESS cycles, never when hang is set.
  int         wait_n;
  bit         err_mode, hang;
  int         acc_cnt;
  logic [7:0] mem [256];

  assign pready  = psel && penable && !hang && (acc_cnt >= wait_n);
  assign pslverr = pready && err_mode;
  assign prdata  = mem[paddr];

  always @(posedge pclk or negedge presetn) begin
    if (!presetn)                      acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                               acc_cnt <= 0;
  end

  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  typedef struct { int port; logic err; logic [7:0] rdata; } exp_t;
  exp_t       sb_q [$];
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic exp_t predict(input int port, input bit wr, input logic [7:0] a,
                                   input logic [7:0] d);
    exp_t e;
    e.port = port;
    e.err  = hang ? 1'b1 : err_mode;
    if (wr) begin
      if (!hang) ref_mem[a] = d;
      e.rdata = last_rd[port];
    end else begin
      e.rdata = hang ? 8'h00 : ref_mem[a];
      last_rd[port] = e.rdata;
    end
    return e;
  endfunction

  task automatic drive_req(input int port, input bit v, input bit w, input logic [7:0] a,
                           input logic [7:0] d);
    if (port == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  exp_t mon_e;
  int   mon_p;
  always @(negedge pclk) begin
    if (presetn && (req0_done || req1_done)) begin
      if (req0_done && req1_done) check("done_both", 1, 0);
      else if (sb_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        mon_e = sb_q.pop_front();
        mon_p = req1_done ? 1 : 0;
        check("sb_port", mon_p, mon_e.port);
        check("sb_err", req1_done ? req1_err : req0_err, mon_e.err);
        check("sb_rdata", req1_done ? req1_rdata : req0_rdata, mon_e.rdata);
      end
    end
  end

  // One transfer on one port; checks bus stability and busy while selected.
  task automatic do_xfer(input int port, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input bit scramble, output int lat, output int nacc);
    int t0;
    bit got;
    sb_q.push_back(predict(port, wr, a, d));
    drive_req(port, 1, wr, a, d);
    t0 = cyc; lat = -1; nacc = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk);
      check("busy_eq_psel", busy, psel);
      if (psel) begin
        check("paddr_stable", paddr, a);
        check("pwrite_stable", pwrite, wr);
        if (wr) check("pwdata_stable", pwdata, d);
        if (scramble) drive_req(port, 1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
      if (psel && penable) nacc++;
      if ((port == 0 && req0_done) || (port == 1 && req1_done)) begin
        got = 1;
        lat = cyc - t0;
        check("psel_in_done", psel, 0);
      end
    end
    if (!got) check("done_wait", 0, 1);
    drive_req(port, 0, 0, 8'h00, 8'h00);
    @(negedge pclk);
  endtask

  task automatic pair_xfer(input logic [7:0] a0, input logic [7:0] d0, input logic [7:0] a1,
                           input logic [7:0] d1);
    int t0, first;
    bit g0, g1;
    sb_q.push_back(predict(0, 1, a0, d0));
    sb_q.push_back(predict(1, 1, a1, d1));
    drive_req(0, 1, 1, a0, d0);
    drive_req(1, 1, 1, a1, d1);
    t0 = cyc; g0 = 0; g1 = 0; first = -1;
    for (int i = 0; i < 40 && !(g0 && g1); i++) begin
      @(negedge pclk);
      if (req1_done && !g1) begin
        g1 = 1;
        if (first < 0) first = 1;
        check("pair_lat1", cyc - t0, 8);
        drive_req(1, 0, 0, 8'h00, 8'h00);
      end
      if (req0_done && !g0) begin
        g0 = 1;
        if (first < 0) first = 0;
        check("pair_lat0", cyc - t0, 4);
        check("pair_psel_in_done", psel, 0);
        drive_req(0, 0, 0, 8'h00, 8'h00);
        @(negedge pclk);
        check("pair_p1_setup", {psel, penable}, 2'b10);
        check("pair_p1_addr", paddr, a1);
        check("pair_p1_wdata", pwdata, d1);
      end
    end
    check("pair_both_done", {g0, g1}, 2'b11);
    check("pair_first", first, 0);
    @(negedge pclk);
  endtask

  task automatic alt_run(input int n);
    int c0, c1, last_t;
    c0 = 0; c1 = 0; last_t = -1;
    for (int k = 0; k < n; k++) begin
      sb_q.push_back(predict(0, 0, 8'h10, 8'h00));
      sb_q.push_back(predict(1, 0, 8'h20, 8'h00));
    end
    drive_req(0, 1, 0, 8'h10, 8'h00);
    drive_req(1, 1, 0, 8'h20, 8'h00);
    for (int i = 0; i < 80 && (c0 < n || c1 < n); i++) begin
      @(negedge pclk);
      if (req0_done || req1_done) begin
        if (last_t >= 0) check("alt_spacing", cyc - last_t, 4);
        last_t = cyc;
        if (req0_done) begin c0++; if (c0 == n) drive_req(0, 0, 0, 8'h00, 8'h00); end
        if (req1_done) begin c1++; if (c1 == n) drive_req(1, 0, 0, 8'h00, 8'h00); end
      end
    end
    check("alt_count", c0 + c1, 2 * n);
    @(negedge pclk);
  endtask

  task automatic apply_reset();
    presetn = 1'b0;
    drive_req(0, 0, 0, 8'h00, 8'h00);
    drive_req(1, 0, 0, 8'h00, 8'h00);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge pclk);
  endtask

  task automatic reset_mid();
    bit seen;
    seen = 0;
    drive_req(0, 1, 0, 8'h10, 8'h00);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge pclk);
      if (psel && penable) seen = 1;
    end
    check("rm_access_seen", seen, 1);
    presetn = 1'b0;
    #1;
    check("rm_psel", psel, 0);
    check("rm_penable", penable, 0);
    check("rm_busy", busy, 0);
    drive_req(0, 0, 0, 8'h00, 8'h00);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    repeat (3) begin
      @(negedge pclk);
      check("rm_no_done", {req0_done, req1_done}, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int lat, nacc;
    presetn = 1'b1;
    drive_req(0, 0, 0, 8'h00, 8'h00);
    drive_req(1, 0, 0, 8'h00, 8'h00);
    wait_n = 1; err_mode = 0; hang = 0;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    #2 presetn = 1'b0;
    repeat (2) @(negedge pclk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {req0_done, req1_done}, 0);
    check("rst_err", {req0_err, req1_err}, 0);
    check("rst_rdata0", req0_rdata, 0);
    check("rst_rdata1", req1_rdata, 0);
    presetn = 1'b1;
    @(negedge pclk);

    // Write then read back with a registered-pready completer.
    do_xfer(0, 1, 8'h3C, 8'hA5, 0, lat, nacc);
    check("wr_lat", lat, 4);
    check("wr_nacc", nacc, 2);
    do_xfer(0, 0, 8'h3C, 8'h00, 0, lat, nacc);
    check("rd_lat", lat, 4);

    wait_n = 0;
    do_xfer(1, 0, 8'h3C, 8'h00, 0, lat, nacc);
    check("zw_lat", lat, 3);
    check("zw_nacc", nacc, 1);

    // Requester inputs change while the transfer is in flight.
    wait_n = 2;
    do_xfer(0, 1, 8'h5A, 8'hC3, 1, lat, nacc);
    check("scr_lat", lat, 5);
    do_xfer(1, 0, 8'h5A, 8'h00, 1, lat, nacc);
    check("scr_nacc", nacc, 3);

    wait_n = 1;
    err_mode = 1;
    do_xfer(0, 1, 8'h11, 8'h77, 0, lat, nacc);
    err_mode = 0;
    do_xfer(0, 0, 8'h11, 8'h00, 0, lat, nacc);
    err_mode = 1;
    do_xfer(1, 0, 8'h3C, 8'h00, 0, lat, nacc);
    err_mode = 0;
    do_xfer(1, 0, 8'h11, 8'h00, 0, lat, nacc);

    hang = 1;
    do_xfer(1, 0, 8'h55, 8'h00, 0, lat, nacc);
    check("to_nacc", nacc, 4);
    check("to_lat", lat, 6);
    hang = 0;
    // pready arrives in the same cycle the counter reaches the limit.
    wait_n = 3;
    do_xfer(1, 0, 8'h3C, 8'h00, 0, lat, nacc);
    check("to_edge_nacc", nacc, 4);
    check("to_edge_lat", lat, 6);

    wait_n = 1;
    apply_reset();
    pair_xfer(8'h10, 8'hD0, 8'h20, 8'hD1);
    alt_run(3);

    do_xfer(0, 0, 8'h10, 8'h00, 0, lat, nacc);
    reset_mid();
    pair_xfer(8'h30, 8'hE0, 8'h40, 8'hE1);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
